shift_seq: RTL and testbench

- Command sequencer that sits directly upstream of the 4-bit load/shift register and drives its D_in and shift_dir inputs.
- Accepts one command at a time over a valid/ready handshake. Each command is "load DATA, then shift COUNT times in direction DIR".
- The downstream register loads on any non-zero D_in and shifts on D_in == 0. This block therefore also keeps a shadow copy of the register contents, so the register holds its value while no command is active.

---
 rtl/shift_seq_pkg.sv | 14 +
 rtl/shift_seq_if.sv | 16 +
 rtl/shift_seq.sv | 77 +++++++
 tb/tb_shift_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: FSM states, shift direction codes and the shadow shift helper.
package shift_seq_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Operates on a zero-extended value; callers truncate to their own width.
    function automatic logic [31:0] shift_next(input logic [31:0] s, input logic dir);
        return (dir == DIR_RIGHT) ? s >> 1 : s << 1;
    endfunction

endpackage

// File: rtl/shift_seq_if.sv
// shift_seq_if: valid/ready command channel carrying load data, direction and shift count.
interface shift_seq_if #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [CW-1:0]    cmd_count;

    modport master (output cmd_valid, cmd_data, cmd_dir, cmd_count, input cmd_ready);
    modport slave  (input cmd_valid, cmd_data, cmd_dir, cmd_count, output cmd_ready);

endinterface

// File: rtl/shift_seq.sv
// shift_seq: sequences load-then-shift commands onto a load/shift register and tracks its contents.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    shift_seq_if.slave       cmd,
    output logic [WIDTH-1:0] D_in,
    output logic             shift_dir,
    output logic             sr_clear,
    output logic [WIDTH-1:0] shadow,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic [CW-1:0]    count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            data_q   <= '0;
            dir_q    <= DIR_LEFT;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            dir_q    <= dir_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        dir_d    = dir_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    data_d  = cmd.cmd_data;
                    dir_d   = cmd.cmd_dir;
                    count_d = cmd.cmd_count;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shadow_d = data_q;
                state_d  = (count_q != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                shadow_d = WIDTH'(shift_next(32'(shadow_q), dir_q));
                count_d  = count_q - 1'b1;
                state_d  = (count_q == CW'(1)) ? DONE : SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outside LOAD/SHIFT the register is fed its own value so it holds.
    assign cmd.cmd_ready = !reset && state_q == IDLE;
    assign D_in      = reset ? '0 : state_q == LOAD ? data_q : state_q == SHIFT ? '0 : shadow_q;
    assign shift_dir = !reset && state_q == SHIFT ? dir_q : DIR_LEFT;
    assign sr_clear  = !reset && state_q == LOAD && data_q == '0;
    assign done      = !reset && state_q == DONE;
    assign shadow    = shadow_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed checks of shift_seq driving a behavioural 4-bit load/shift register.
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] D_in;
    logic       shift_dir;
    logic       sr_clear;
    logic [3:0] shadow;
    logic       done;
    logic [3:0] d_out;
    int         errors = 0;
    int         checks = 0;

    shift_seq_if #(.WIDTH(4), .CW(3)) cmd_if ();

    shift_seq #(.WIDTH(4), .CW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_if),
        .D_in      (D_in),
        .shift_dir (shift_dir),
        .sr_clear  (sr_clear),
        .shadow    (shadow),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Downstream register: loads non-zero D_in, shifts on zero, cleared by its reset.
    always_ff @(posedge clk) begin
        if (reset || sr_clear) d_out <= 4'b0000;
        else if (D_in != 4'b0000) d_out <= D_in;
        else d_out <= shift_dir ? d_out >> 1 : d_out << 1;
    end

    task automatic issue(input logic [3:0] d, input logic dir, input logic [2:0] n);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = d;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_count = n;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 4'b0000;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_count = 3'd0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cmd_if.cmd_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready c%0d got %b want 1", i, cmd_if.cmd_ready); end
            checks++; if (D_in !== 4'b0000) begin errors++; $display("FAIL idle_din c%0d got %b want 0000", i, D_in); end
            checks++; if (shadow !== 4'b0000) begin errors++; $display("FAIL idle_shadow c%0d got %b want 0000", i, shadow); end
            checks++; if (d_out !== 4'b0000) begin errors++; $display("FAIL idle_dout c%0d got %b want 0000", i, d_out); end
        end
    endtask

    task automatic test_right_shift();
        logic [3:0] e_sh  [5] = '{4'b0000, 4'b1011, 4'b0101, 4'b0010, 4'b0010};
        logic [3:0] e_din [5] = '{4'b1011, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
        logic       e_dn  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       e_rdy [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       e_sd  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        issue(4'b1011, 1'b1, 3'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (shadow !== e_sh[i]) begin errors++; $display("FAIL right_shadow c%0d got %b want %b", i + 1, shadow, e_sh[i]); end
            checks++; if (D_in !== e_din[i]) begin errors++; $display("FAIL right_din c%0d got %b want %b", i + 1, D_in, e_din[i]); end
            checks++; if (done !== e_dn[i]) begin errors++; $display("FAIL right_done c%0d got %b want %b", i + 1, done, e_dn[i]); end
            checks++; if (cmd_if.cmd_ready !== e_rdy[i]) begin errors++; $display("FAIL right_ready c%0d got %b want %b", i + 1, cmd_if.cmd_ready, e_rdy[i]); end
            checks++; if (shift_dir !== e_sd[i]) begin errors++; $display("FAIL right_dir c%0d got %b want %b", i + 1, shift_dir, e_sd[i]); end
            checks++; if (d_out !== e_sh[i]) begin errors++; $display("FAIL right_dout c%0d got %b want %b", i + 1, d_out, e_sh[i]); end
            if (i == 0) cmd_if.cmd_valid = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (d_out !== 4'b0010 || shadow !== 4'b0010) begin errors++; $display("FAIL right_hold c%0d got dout %b shadow %b want 0010", i, d_out, shadow); end
        end
    endtask

    task automatic test_left_shift();
        logic [3:0] e_sh  [6] = '{4'b0010, 4'b0011, 4'b0110, 4'b1100, 4'b1000, 4'b1000};
        logic [3:0] e_din [6] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
        logic       e_dn  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       e_rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        issue(4'b0011, 1'b0, 3'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (shadow !== e_sh[i]) begin errors++; $display("FAIL left_shadow c%0d got %b want %b", i + 1, shadow, e_sh[i]); end
            checks++; if (D_in !== e_din[i]) begin errors++; $display("FAIL left_din c%0d got %b want %b", i + 1, D_in, e_din[i]); end
            checks++; if (done !== e_dn[i]) begin errors++; $display("FAIL left_done c%0d got %b want %b", i + 1, done, e_dn[i]); end
            checks++; if (cmd_if.cmd_ready !== e_rdy[i]) begin errors++; $display("FAIL left_ready c%0d got %b want %b", i + 1, cmd_if.cmd_ready, e_rdy[i]); end
            checks++; if (d_out !== e_sh[i]) begin errors++; $display("FAIL left_dout c%0d got %b want %b", i + 1, d_out, e_sh[i]); end
            if (i == 0) cmd_if.cmd_valid = 1'b0;
        end
    endtask

    task automatic test_zero_load();
        logic [3:0] e_sh [3] = '{4'b1000, 4'b0000, 4'b0000};
        logic       e_sr [3] = '{1'b1, 1'b0, 1'b0};
        logic       e_dn [3] = '{1'b0, 1'b1, 1'b0};
        issue(4'b0000, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (sr_clear !== e_sr[i]) begin errors++; $display("FAIL zero_clear c%0d got %b want %b", i + 1, sr_clear, e_sr[i]); end
            checks++; if (D_in !== 4'b0000) begin errors++; $display("FAIL zero_din c%0d got %b want 0000", i + 1, D_in); end
            checks++; if (shadow !== e_sh[i]) begin errors++; $display("FAIL zero_shadow c%0d got %b want %b", i + 1, shadow, e_sh[i]); end
            checks++; if (done !== e_dn[i]) begin errors++; $display("FAIL zero_done c%0d got %b want %b", i + 1, done, e_dn[i]); end
            checks++; if (d_out !== e_sh[i]) begin errors++; $display("FAIL zero_dout c%0d got %b want %b", i + 1, d_out, e_sh[i]); end
            if (i == 0) cmd_if.cmd_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e_sh  [8] = '{4'b0000, 4'b0101, 4'b1010, 4'b1010, 4'b1010, 4'b1001, 4'b0100, 4'b0100};
        logic [3:0] e_din [8] = '{4'b0101, 4'b0000, 4'b1010, 4'b1010, 4'b1001, 4'b0000, 4'b0100, 4'b0100};
        logic       e_dn  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       e_rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int         n_done = 0;
        issue(4'b0101, 1'b0, 3'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_done += int'(done);
            checks++; if (shadow !== e_sh[i]) begin errors++; $display("FAIL b2b_shadow c%0d got %b want %b", i + 1, shadow, e_sh[i]); end
            checks++; if (D_in !== e_din[i]) begin errors++; $display("FAIL b2b_din c%0d got %b want %b", i + 1, D_in, e_din[i]); end
            checks++; if (done !== e_dn[i]) begin errors++; $display("FAIL b2b_done c%0d got %b want %b", i + 1, done, e_dn[i]); end
            checks++; if (cmd_if.cmd_ready !== e_rdy[i]) begin errors++; $display("FAIL b2b_ready c%0d got %b want %b", i + 1, cmd_if.cmd_ready, e_rdy[i]); end
            checks++; if (d_out !== e_sh[i]) begin errors++; $display("FAIL b2b_dout c%0d got %b want %b", i + 1, d_out, e_sh[i]); end
            if (i == 0) issue(4'b1001, 1'b1, 3'd1);
            if (i == 4) cmd_if.cmd_valid = 1'b0;
        end
        checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", n_done); end
    endtask

    task automatic test_reset_mid_shift();
        logic [3:0] e_sh  [4] = '{4'b0000, 4'b0110, 4'b1100, 4'b1100};
        logic [3:0] e_din [4] = '{4'b0110, 4'b0000, 4'b1100, 4'b1100};
        logic       e_dn  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       e_rdy [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] a_sh  [3] = '{4'b0100, 4'b1111, 4'b0111};
        issue(4'b1111, 1'b1, 3'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (shadow !== a_sh[i]) begin errors++; $display("FAIL abort_shadow c%0d got %b want %b", i + 1, shadow, a_sh[i]); end
            if (i == 0) cmd_if.cmd_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (cmd_if.cmd_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_during got ready %b done %b want 0 0", cmd_if.cmd_ready, done); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (shadow !== 4'b0000 || d_out !== 4'b0000) begin errors++; $display("FAIL abort_clear c%0d got shadow %b dout %b want 0000", i, shadow, d_out); end
            checks++; if (done !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle c%0d got done %b ready %b want 0 1", i, done, cmd_if.cmd_ready); end
        end
        issue(4'b0110, 1'b0, 3'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (shadow !== e_sh[i]) begin errors++; $display("FAIL recover_shadow c%0d got %b want %b", i + 1, shadow, e_sh[i]); end
            checks++; if (D_in !== e_din[i]) begin errors++; $display("FAIL recover_din c%0d got %b want %b", i + 1, D_in, e_din[i]); end
            checks++; if (done !== e_dn[i]) begin errors++; $display("FAIL recover_done c%0d got %b want %b", i + 1, done, e_dn[i]); end
            checks++; if (cmd_if.cmd_ready !== e_rdy[i]) begin errors++; $display("FAIL recover_ready c%0d got %b want %b", i + 1, cmd_if.cmd_ready, e_rdy[i]); end
            checks++; if (d_out !== e_sh[i]) begin errors++; $display("FAIL recover_dout c%0d got %b want %b", i + 1, d_out, e_sh[i]); end
            if (i == 0) cmd_if.cmd_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_right_shift();
        test_left_shift();
        test_zero_load();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
